alu_out_result_tx: RTL and testbench
====================================

// Module: alu_out_result_tx
// PURPOSE
//   Transmit end of the alu_out interface. Accepts results from the ALU datapath over a
//   valid/ready handshake, buffers them, and presents each on result with a one-cycle done
//   pulse. This is the protocol the alu_out monitor samples. Sits between the ALU core
//   and the alu_out_if pins.
// PARAMETERS
//   ALU_OUT_RESULT_WIDTH  16  width of in_result / result
//   FIFO_DEPTH            4   result buffer entries; power of 2, >= 2
//   MIN_GAP               0   minimum idle cycles between consecutive done pulses (0..255)
// PORTS
//   clk        in   1                         single clock, all logic on posedge
//   rst        in   1                         asynchronous, active-low reset
//   in_valid   in   1                         ALU core offers in_result
//   in_ready   out  1                         block can accept; transfer = in_valid & in_ready
//   in_result  in   ALU_OUT_RESULT_WIDTH      result from ALU core
//   done       out  1                         one-cycle pulse: result is valid this cycle
//   result     out  ALU_OUT_RESULT_WIDTH      presented result; held until next done
//   fifo_count out  $clog2(FIFO_DEPTH)+1      entries currently buffered
// BEHAVIOUR
//   Reset (rst=0, async): done=0, result=0, in_ready=0 while asserted, fifo_count=0,
//     FIFO pointers cleared, FSM->IDLE, gap counter=0. After release in_ready=1 from first edge.
//   in_ready = (fifo_count != FIFO_DEPTH); it does not depend on a same-cycle pop, so there
//     is no write when full. An in_valid with in_ready=0 is held by the core (no drop).
//   No bypass: a word written on edge E is popped no earlier than edge E+1. Then done=1 in
//     the cycle after edge E+1, so minimum latency is 2 edges from accept to done sample.
//   FSM (registered outputs):
//     IDLE:    if fifo non-empty -> pop, result<=head, done<=1, -> PRESENT.
//     PRESENT: done<=0. If MIN_GAP==0 and fifo non-empty -> pop again (done stays 1,
//              back-to-back), else if MIN_GAP>0 -> gap<=MIN_GAP-1, -> GAP, else -> IDLE.
//     GAP:     done=0; gap counts down; at gap==0 -> IDLE (pop allowed on that same edge
//              if non-empty, so exactly MIN_GAP idle cycles separate pulses).
//   With MIN_GAP=0 and a continuously non-empty FIFO, done stays high every cycle with a
//     new result each cycle. Throughput is 1/(MIN_GAP+1).
//   result is updated only on a pop; it retains the last value while done=0.
//   Simultaneous push+pop: count unchanged, both pointers advance. Pointers wrap modulo
//     FIFO_DEPTH. fifo_count is exact, and is FIFO_DEPTH only when full.
//   Reset mid-operation discards all buffered and in-flight results; no done after release
//     until a new transfer.
//   Arithmetic: counters are unsigned; no saturation is needed (full guard).
// STRUCTURE
//   Package alu_out_tx_pkg: typedef enum logic [1:0] {IDLE, PRESENT, GAP} alu_out_tx_state_t;
//     localparam for gap counter width (8).
//   Sub-module alu_out_tx_fifo: sync FIFO, parameterised width/depth. Ports are push, pop,
//     din, dout (head, combinational), count, full, empty. Same clk/rst.
//   Top holds the FSM, gap counter and output registers.
// TESTING
//   1 Reset release, single push 16'h00A5 -> in_ready=1, done high exactly 1 cycle at
//     accept+2, result=16'h00A5, result held afterwards.
//   2 MIN_GAP=0, push 1,2,3,4 back-to-back -> done high 4 consecutive cycles, result 1,2,3,4.
//     fifo_count never exceeds 2.
//   3 FIFO_DEPTH=4, MIN_GAP=3, push 6 words continuously -> in_ready drops at count=4.
//     Pulses are 4 cycles apart and all 6 values arrive in order, none lost.
//   4 Fill FIFO to 4, pull rst low mid-pulse -> done=0, result=0, fifo_count=0 immediately
//     (async). No done after release until a new push.
//   5 Push and pop on the same edge at count=2 -> count stays 2. Pointer wrap verified
//     over 3*FIFO_DEPTH words.
//   6 Monitor cross-check: alu_out monitor on the pins reports results equal to the push
//     sequence (scoreboard, 1000 random words, random in_valid gaps).

Source files
------------

// File: rtl/alu_out_tx_pkg.sv
// Shared types and constants for the alu_out transmit block.
package alu_out_tx_pkg;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} alu_out_tx_state_t;

  localparam int unsigned GAP_W = 8;

endpackage

// File: rtl/alu_out_tx_fifo.sv
// Synchronous FIFO with combinational head, exact occupancy count and full/empty flags.
module alu_out_tx_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_out_result_tx.sv
// alu_out transmit end: buffers ALU results and presents each with a one-cycle done pulse,
// separated by at least MIN_GAP idle cycles.
module alu_out_result_tx
  import alu_out_tx_pkg::*;
#(
  parameter int unsigned ALU_OUT_RESULT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH           = 4,
  parameter int unsigned MIN_GAP              = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ALU_OUT_RESULT_WIDTH-1:0]   in_result,
  output logic                              done,
  output logic [ALU_OUT_RESULT_WIDTH-1:0]   result,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
  localparam bit          NO_GAP = (MIN_GAP == 0);

  alu_out_tx_state_t               r_state;
  logic [GAP_W-1:0]                r_gap;
  logic                            r_done;
  logic                            r_in_ready;
  logic [ALU_OUT_RESULT_WIDTH-1:0] r_result;
  logic [ALU_OUT_RESULT_WIDTH-1:0] w_head;
  logic                            w_full;
  logic                            w_empty;
  logic                            w_push;
  logic                            w_pop;
  logic [CW-1:0]                   w_count_nxt;

  assign in_ready = r_in_ready;
  assign done     = r_done;
  assign result   = r_result;
  assign w_push   = in_valid & r_in_ready & ~w_full;

  alu_out_tx_fifo #(
    .WIDTH (ALU_OUT_RESULT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_result),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Pop decision: the FSM consumes the head whenever it is allowed to present.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = ~w_empty;
      PRESENT: w_pop = NO_GAP & ~w_empty;
      GAP:     w_pop = (r_gap == '0) & ~w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  always_comb begin
    w_count_nxt = fifo_count;
    if (w_push && !w_pop)      w_count_nxt = fifo_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = fifo_count - CW'(1);
  end

  // in_ready is registered from the post-edge occupancy so it never tracks a same-cycle pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_gap      <= '0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b0;
      r_result   <= '0;
    end else begin
      r_in_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
      r_done     <= w_pop;
      if (w_pop) r_result <= w_head;
      case (r_state)
        IDLE: begin
          if (w_pop) r_state <= PRESENT;
        end
        PRESENT: begin
          if (!w_pop) begin
            if (!NO_GAP) begin
              r_gap   <= GAP_W'(MIN_GAP - 1);
              r_state <= GAP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          if (r_gap == '0) r_state <= w_pop ? PRESENT : IDLE;
          else             r_gap   <= r_gap - GAP_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_out_result_tx.sv
// Directed table plus scoreboard bench for alu_out_result_tx (MIN_GAP=0 and MIN_GAP=3 instances).
module tb_alu_out_result_tx;

  localparam int NRAND  = 1000;
  localparam int BUDGET = 20000;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        dn;
    logic [15:0] res;
    logic [2:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_s [2];
  logic [15:0] data_s  [2];
  logic        ready_s [2];
  logic        done_s  [2];
  logic [15:0] res_s   [2];
  logic [2:0]  cnt_s   [2];

  int n_vec = 0;
  int n_err = 0;

  vec_t tab0 [10];
  vec_t tab3 [28];

  always #5 clk = ~clk;

  alu_out_result_tx #(.ALU_OUT_RESULT_WIDTH(16), .FIFO_DEPTH(4), .MIN_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(valid_s[0]), .in_ready(ready_s[0]),
    .in_result(data_s[0]), .done(done_s[0]), .result(res_s[0]), .fifo_count(cnt_s[0])
  );

  alu_out_result_tx #(.ALU_OUT_RESULT_WIDTH(16), .FIFO_DEPTH(4), .MIN_GAP(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(valid_s[1]), .in_ready(ready_s[1]),
    .in_result(data_s[1]), .done(done_s[1]), .result(res_s[1]), .fifo_count(cnt_s[1])
  );

  function automatic vec_t mk(logic v, logic [15:0] d, logic rdy, logic dn,
                              logic [15:0] res, logic [2:0] cnt);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.dn = dn; t.res = res; t.cnt = cnt;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(string tag, int idx, int u, vec_t t);
    n_vec++;
    if (ready_s[u] !== t.rdy || done_s[u] !== t.dn || res_s[u] !== t.res || cnt_s[u] !== t.cnt) begin
      n_err++;
      $display("FAIL %s[%0d]: got rdy=%b done=%b result=%h count=%0d expected rdy=%b done=%b result=%h count=%0d",
               tag, idx, ready_s[u], done_s[u], res_s[u], cnt_s[u], t.rdy, t.dn, t.res, t.cnt);
    end
  endtask

  task automatic run_table0();
    for (int i = 0; i < 10; i++) begin
      valid_s[0] = tab0[i].v;
      data_s[0]  = tab0[i].d;
      tick();
      chk_row("tab0", i, 0, tab0[i]);
    end
    valid_s[0] = 1'b0;
  endtask

  task automatic run_table3();
    for (int i = 0; i < 28; i++) begin
      valid_s[1] = tab3[i].v;
      data_s[1]  = tab3[i].d;
      tick();
      chk_row("tab3", i, 1, tab3[i]);
    end
    valid_s[1] = 1'b0;
  endtask

  // Scoreboard: every done must present the oldest accepted word; spacing enforced when gap>0.
  task automatic run_random(input int u, input int gap);
    logic [15:0] q[$];
    logic [15:0] wd;
    logic [15:0] exp_w;
    logic        wp;
    int          pushed;
    int          cyc;
    int          last;
    pushed = 0;
    cyc    = 0;
    last   = -100;
    valid_s[u] = 1'b0;
    while ((pushed < NRAND || q.size() != 0) && cyc < BUDGET) begin
      if (!valid_s[u] && pushed < NRAND && $urandom_range(0, 3) != 0) begin
        valid_s[u] = 1'b1;
        data_s[u]  = 16'($urandom);
      end
      wp = valid_s[u] & ready_s[u];
      wd = data_s[u];
      tick();
      cyc++;
      if (wp) begin
        q.push_back(wd);
        pushed++;
        valid_s[u] = 1'b0;
      end
      if (done_s[u]) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand%0d_spurious: got done with result %h expected no done", u, res_s[u]);
        end else begin
          exp_w = q.pop_front();
          chk($sformatf("rand%0d_result", u), 32'(res_s[u]), 32'(exp_w));
        end
        if (gap > 0) chk($sformatf("rand%0d_spacing_ok", u), 32'(cyc - last > gap), 32'd1);
        last = cyc;
      end
      chk($sformatf("rand%0d_ready_vs_count", u), 32'(ready_s[u]), 32'(cnt_s[u] != 3'd4));
    end
    valid_s[u] = 1'b0;
    if (cyc >= BUDGET) begin
      n_vec++;
      n_err++;
      $display("FAIL rand%0d_timeout: got %0d words outstanding expected 0", u, q.size());
    end
  endtask

  initial begin
    valid_s[0] = 1'b0; valid_s[1] = 1'b0;
    data_s[0]  = '0;   data_s[1]  = '0;

    // MIN_GAP=0: single word, then four back-to-back words.
    tab0[0] = mk(1, 16'h00A5, 1, 0, 16'h0000, 3'd1);
    tab0[1] = mk(0, 16'h0000, 1, 1, 16'h00A5, 3'd0);
    tab0[2] = mk(0, 16'h0000, 1, 0, 16'h00A5, 3'd0);
    tab0[3] = mk(0, 16'h0000, 1, 0, 16'h00A5, 3'd0);
    tab0[4] = mk(1, 16'h0001, 1, 0, 16'h00A5, 3'd1);
    tab0[5] = mk(1, 16'h0002, 1, 1, 16'h0001, 3'd1);
    tab0[6] = mk(1, 16'h0003, 1, 1, 16'h0002, 3'd1);
    tab0[7] = mk(1, 16'h0004, 1, 1, 16'h0003, 3'd1);
    tab0[8] = mk(0, 16'h0000, 1, 1, 16'h0004, 3'd0);
    tab0[9] = mk(0, 16'h0000, 1, 0, 16'h0004, 3'd0);

    // MIN_GAP=3: fill to full, backpressure, pulses every 4 cycles, push+pop at count 2.
    tab3[0]  = mk(1, 16'h0031, 1, 0, 16'h0000, 3'd1);
    tab3[1]  = mk(1, 16'h0032, 1, 1, 16'h0031, 3'd1);
    tab3[2]  = mk(1, 16'h0033, 1, 0, 16'h0031, 3'd2);
    tab3[3]  = mk(1, 16'h0034, 1, 0, 16'h0031, 3'd3);
    tab3[4]  = mk(1, 16'h0035, 0, 0, 16'h0031, 3'd4);
    tab3[5]  = mk(1, 16'h0036, 1, 1, 16'h0032, 3'd3);
    tab3[6]  = mk(1, 16'h0036, 0, 0, 16'h0032, 3'd4);
    tab3[7]  = mk(0, 16'h0000, 0, 0, 16'h0032, 3'd4);
    tab3[8]  = mk(0, 16'h0000, 0, 0, 16'h0032, 3'd4);
    tab3[9]  = mk(0, 16'h0000, 1, 1, 16'h0033, 3'd3);
    for (int i = 10; i < 13; i++) tab3[i] = mk(0, 16'h0000, 1, 0, 16'h0033, 3'd3);
    tab3[13] = mk(0, 16'h0000, 1, 1, 16'h0034, 3'd2);
    for (int i = 14; i < 17; i++) tab3[i] = mk(0, 16'h0000, 1, 0, 16'h0034, 3'd2);
    tab3[17] = mk(1, 16'h0037, 1, 1, 16'h0035, 3'd2);
    for (int i = 18; i < 21; i++) tab3[i] = mk(0, 16'h0000, 1, 0, 16'h0035, 3'd2);
    tab3[21] = mk(0, 16'h0000, 1, 1, 16'h0036, 3'd1);
    for (int i = 22; i < 25; i++) tab3[i] = mk(0, 16'h0000, 1, 0, 16'h0036, 3'd1);
    tab3[25] = mk(0, 16'h0000, 1, 1, 16'h0037, 3'd0);
    tab3[26] = mk(0, 16'h0000, 1, 0, 16'h0037, 3'd0);
    tab3[27] = mk(0, 16'h0000, 1, 0, 16'h0037, 3'd0);

    // Reset state, before any clock edge.
    #2;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_ready%0d", u), 32'(ready_s[u]), 32'd0);
      chk($sformatf("reset_done%0d", u),  32'(done_s[u]),  32'd0);
      chk($sformatf("reset_result%0d", u), 32'(res_s[u]), 32'd0);
      chk($sformatf("reset_count%0d", u), 32'(cnt_s[u]),  32'd0);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("release_ready0", 32'(ready_s[0]), 32'd1);
    chk("release_ready1", 32'(ready_s[1]), 32'd1);

    run_table0();
    run_table3();

    // Reset in the middle of a done pulse with a nearly full buffer.
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 5; i++) begin
      valid_s[1] = 1'b1;
      data_s[1]  = 16'h0041 + 16'(i);
      tick();
    end
    valid_s[1] = 1'b0;
    chk("fill_count", 32'(cnt_s[1]), 32'd4);
    chk("fill_ready", 32'(ready_s[1]), 32'd0);
    tick();
    chk("pulse_before_reset", 32'(done_s[1]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_done",   32'(done_s[1]),  32'd0);
    chk("midreset_result", 32'(res_s[1]),   32'd0);
    chk("midreset_count",  32'(cnt_s[1]),   32'd0);
    chk("midreset_ready",  32'(ready_s[1]), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post_reset_done[%0d]", i), 32'(done_s[1]), 32'd0);
    end
    chk("post_reset_count", 32'(cnt_s[1]), 32'd0);
    chk("post_reset_ready", 32'(ready_s[1]), 32'd1);

    run_random(0, 0);
    run_random(1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
